// File: rtl/alu_uart_interface_if.sv
// Signal bundle between the UART/ALU bridge and its surroundings.
// The slave modport is the bridge's view; master is the driving side.
interface alu_uart_interface_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_alu_overflow;
    logic               i_alu_zero;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_operation_code;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done,
        input  i_alu_result, i_alu_overflow, i_alu_zero,
        output o_data_a, o_data_b, o_operation_code,
        output o_tx_data, o_tx_start, o_busy
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done,
        output i_alu_result, i_alu_overflow, i_alu_zero,
        input  o_data_a, o_data_b, o_operation_code,
        input  o_tx_data, o_tx_start, o_busy
    );
endinterface

// File: rtl/alu_uart_interface.sv
// UART-to-ALU bridge: collects A, B and op bytes, lets the ALU settle for
// one cycle, then returns the result byte followed by the flags byte.
module alu_uart_interface #(
    parameter int          NB_DATA        = 8,
    parameter int          NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    alu_uart_interface_if.slave  bus
);

    localparam int          CW_RAW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int          CW           = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES != 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LIMIT      = CW'(TIMEOUT_LAST);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND_RES,
        WAIT_RES,
        SEND_FLG,
        WAIT_FLG
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CW-1:0]      cnt_q;
    logic               timeout_hit;
    logic               collecting;
    logic [NB_DATA-1:0] data_a_q;
    logic [NB_DATA-1:0] data_b_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] tx_data_q;
    logic [NB_DATA-1:0] flags_q;
    logic               tx_start_q;

    assign collecting  = (state_q == WAIT_B) || (state_q == WAIT_OP);
    // Expiry is flagged on the last idle cycle so the return to WAIT_A lands
    // exactly TIMEOUT_CYCLES idle cycles after the previous accepted byte.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == LIMIT);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= WAIT_A;
        else          state_q <= state_d;
    end

    // Next-state logic; a byte arriving on the expiry cycle takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_A:   if (bus.i_rx_done) state_d = WAIT_B;
            WAIT_B:   if (bus.i_rx_done) state_d = WAIT_OP;
                      else if (timeout_hit) state_d = WAIT_A;
            WAIT_OP:  if (bus.i_rx_done) state_d = EXEC;
                      else if (timeout_hit) state_d = WAIT_A;
            EXEC:     state_d = SEND_RES;
            SEND_RES: state_d = WAIT_RES;
            WAIT_RES: if (bus.i_tx_done) state_d = SEND_FLG;
            SEND_FLG: state_d = WAIT_FLG;
            WAIT_FLG: if (bus.i_tx_done) state_d = WAIT_A;
            default:  state_d = WAIT_A;
        endcase
    end

    // Inter-byte idle counter, only running while operands are being collected.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if ((TIMEOUT_CYCLES != 0) && collecting && !bus.i_rx_done && !timeout_hit) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Operand capture, result/flag latching and transmit request generation.
    // tx_data_q doubles as the latched result, so the byte on o_tx_data is
    // loaded on the same edge that raises o_tx_start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            flags_q    <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                WAIT_A:  if (bus.i_rx_done) data_a_q <= bus.i_rx_data;
                WAIT_B:  if (bus.i_rx_done) data_b_q <= bus.i_rx_data;
                WAIT_OP: if (bus.i_rx_done) op_q <= bus.i_rx_data[NB_OP-1:0];
                EXEC: begin
                    tx_data_q  <= bus.i_alu_result;
                    flags_q    <= {{(NB_DATA-2){1'b0}}, bus.i_alu_overflow, bus.i_alu_zero};
                    tx_start_q <= 1'b1;
                end
                WAIT_RES: begin
                    if (bus.i_tx_done) begin
                        tx_data_q  <= flags_q;
                        tx_start_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_data_a         = data_a_q;
    assign bus.o_data_b         = data_b_q;
    assign bus.o_operation_code = op_q;
    assign bus.o_tx_data        = tx_data_q;
    assign bus.o_tx_start       = tx_start_q;
    assign bus.o_busy           = (state_q != WAIT_A);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: directed byte sequences, a transaction-level
// reference model compared every cycle, and literal expectations per scenario.
module tb_alu_uart_interface;

    localparam int TMO = 20;

    logic clk;
    logic rst_n;

    alu_uart_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    alu_uart_interface #(
        .NB_DATA(8),
        .NB_OP(6),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Simple ALU standing in for the real consumer of the operand outputs.
    function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic [7:0] r;
        logic       ovf;
        r   = '0;
        ovf = 1'b0;
        case (op)
            6'h20: begin r = a + b; ovf = (a[7] == b[7]) && (r[7] != a[7]); end
            6'h22: begin r = a - b; ovf = (a[7] != b[7]) && (r[7] != a[7]); end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            default: r = '0;
        endcase
        return {ovf, (r == 8'h00), r};
    endfunction

    assign {bus.i_alu_overflow, bus.i_alu_zero, bus.i_alu_result} =
        alu_fn(bus.o_data_a, bus.o_data_b, bus.o_operation_code);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model (transaction level) ----------------
    logic [7:0] m_a = '0, m_b = '0, m_txd = '0, m_flg = '0;
    logic [5:0] m_op = '0;
    int         m_got = 0;     // operand bytes collected so far
    int         m_idle = 0;    // idle cycles since last accepted byte
    bit         m_exec = 0;    // op accepted, result appears next edge
    int         m_txing = 0;   // 0 none, 1 result byte out, 2 flags byte out
    bit         m_start = 0;
    int         m_cyc = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_a = '0; m_b = '0; m_op = '0; m_txd = '0; m_flg = '0;
                m_got = 0; m_idle = 0; m_exec = 0; m_txing = 0; m_start = 0;
            end else begin
                bit was_start;
                logic [9:0] r;
                was_start = m_start;
                m_start   = 0;
                m_cyc++;
                if (m_exec) begin
                    r       = alu_fn(m_a, m_b, m_op);
                    m_txd   = r[7:0];
                    m_flg   = {6'b0, r[9], r[8]};
                    m_start = 1;
                    m_txing = 1;
                    m_exec  = 0;
                end else if (m_txing != 0) begin
                    if (!was_start && bus.i_tx_done) begin
                        if (m_txing == 1) begin
                            m_txd   = m_flg;
                            m_start = 1;
                            m_txing = 2;
                        end else begin
                            m_txing = 0;
                        end
                    end
                end else if (bus.i_rx_done) begin
                    if (m_got == 0)      m_a  = bus.i_rx_data;
                    else if (m_got == 1) m_b  = bus.i_rx_data;
                    else                 m_op = bus.i_rx_data[5:0];
                    if (m_got == 2) begin
                        m_got  = 0;
                        m_exec = 1;
                    end else begin
                        m_got++;
                    end
                    m_idle = 0;
                end else if (m_got != 0) begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        m_got  = 0;
                        m_idle = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("data_a",   int'(bus.o_data_a),         int'(m_a));
            chk("data_b",   int'(bus.o_data_b),         int'(m_b));
            chk("op_code",  int'(bus.o_operation_code), int'(m_op));
            chk("tx_data",  int'(bus.o_tx_data),        int'(m_txd));
            chk("tx_start", int'(bus.o_tx_start),       int'(m_start));
            chk("busy",     int'(bus.o_busy),
                int'((m_got != 0) || m_exec || (m_txing != 0)));
        end
    end

    // ---------------- transmitter stand-in ----------------
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         tx_delay = 2;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_tx_start) begin
                tx_log.push_back(bus.o_tx_data);
                tx_cyc.push_back(m_cyc);
            end
        end
    end

    initial begin
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_tx_start) begin
                repeat (tx_delay) @(posedge clk);
                #1 bus.i_tx_done = 1'b1;
                @(posedge clk);
                #1 bus.i_tx_done = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int last_drive_cyc = 0;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; one rx pulse followed by one idle cycle.
    task automatic send_byte(input logic [7:0] b);
        last_drive_cyc   = m_cyc;
        bus.i_rx_data    = b;
        bus.i_rx_done    = 1'b1;
        @(posedge clk);
        #1 bus.i_rx_done = 1'b0;
        idle(1);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && bus.o_busy; i++) idle(1);
        chk("idle_wait", int'(bus.o_busy), 0);
    endtask

    task automatic wait_starts(input int target, input int limit);
        for (int i = 0; i < limit && tx_log.size() < target; i++) @(negedge clk);
        chk("start_wait", int'(tx_log.size() >= target), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           output int base, output int op_cyc);
        base = tx_log.size();
        send_byte(a);
        send_byte(b);
        send_byte(op);
        op_cyc = last_drive_cyc;
        wait_idle(300);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int base;
        int op_cyc;
        rst_n          = 1'b0;
        bus.i_rx_data  = '0;
        bus.i_rx_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",     int'(bus.o_busy), 0);
        chk("rst_tx_start", int'(bus.o_tx_start), 0);
        chk("rst_data_a",   int'(bus.o_data_a), 0);
        rst_n = 1'b1;
        idle(2);

        // ADD 5+3
        run_txn(8'h05, 8'h03, 8'h20, base, op_cyc);
        chk("t1_a",   int'(bus.o_data_a), 'h05);
        chk("t1_b",   int'(bus.o_data_b), 'h03);
        chk("t1_op",  int'(bus.o_operation_code), 'h20);
        chk("t1_res", int'(tx_log[base]), 'h08);
        chk("t1_flg", int'(tx_log[base+1]), 'h00);
        chk("t1_lat", tx_cyc[base] - op_cyc, 2);

        // SUB 5-5 -> zero flag
        run_txn(8'h05, 8'h05, 8'h22, base, op_cyc);
        chk("t2_res",  int'(tx_log[base]), 'h00);
        chk("t2_flg",  int'(tx_log[base+1]), 'h01);
        chk("t2_busy", int'(bus.o_busy), 0);

        // op byte with upper bits set, signed overflow
        run_txn(8'h7F, 8'h01, 8'hE0, base, op_cyc);
        chk("t3_op",  int'(bus.o_operation_code), 'h20);
        chk("t3_res", int'(tx_log[base]), 'h80);
        chk("t3_flg", int'(tx_log[base+1]), 'h02);

        // slow transmitter, stray rx bytes while waiting
        tx_delay = 50;
        base = tx_log.size();
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h22);
        wait_starts(base + 1, 50);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        chk("t4_a_kept", int'(bus.o_data_a), 'h10);
        chk("t4_hold",   int'(bus.o_tx_data), 'hF0);
        wait_idle(400);
        chk("t4_starts", tx_log.size() - base, 2);
        chk("t4_res",    int'(tx_log[base]), 'hF0);
        chk("t4_flg",    int'(tx_log[base+1]), 'h00);
        tx_delay = 2;
        run_txn(8'h01, 8'h02, 8'h20, base, op_cyc);
        chk("t4b_a",   int'(bus.o_data_a), 'h01);
        chk("t4b_b",   int'(bus.o_data_b), 'h02);
        chk("t4b_res", int'(tx_log[base]), 'h03);

        // inter-byte timeout: one idle cycle already spent inside send_byte
        send_byte(8'h11);
        idle(18);
        chk("t5_busy_before", int'(bus.o_busy), 1);
        idle(1);
        chk("t5_busy_after", int'(bus.o_busy), 0);
        chk("t5_a_kept",     int'(bus.o_data_a), 'h11);
        idle(5);
        run_txn(8'h02, 8'h03, 8'h24, base, op_cyc);
        chk("t5_a",   int'(bus.o_data_a), 'h02);
        chk("t5_b",   int'(bus.o_data_b), 'h03);
        chk("t5_op",  int'(bus.o_operation_code), 'h24);
        chk("t5_res", int'(tx_log[base]), 'h02);
        chk("t5_flg", int'(tx_log[base+1]), 'h00);

        // reset while waiting for the result byte to finish
        tx_delay = 30;
        base = tx_log.size();
        send_byte(8'h21);
        send_byte(8'h22);
        send_byte(8'h20);
        wait_starts(base + 1, 50);
        idle(5);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_a",        int'(bus.o_data_a), 0);
        chk("t6_b",        int'(bus.o_data_b), 0);
        chk("t6_op",       int'(bus.o_operation_code), 0);
        chk("t6_tx_data",  int'(bus.o_tx_data), 0);
        chk("t6_tx_start", int'(bus.o_tx_start), 0);
        chk("t6_busy",     int'(bus.o_busy), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(40);
        chk("t6_res",      int'(tx_log[base]), 'h43);
        chk("t6_no_flags", tx_log.size() - base, 1);
        chk("t6_idle",     int'(bus.o_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
